cipher_tx_serializer: RTL and testbench
=======================================

CIPHER_TX_SERIALIZER -- requirements
Module: cipher_tx_serializer

Interface
REQ-001 The block SHALL have parameter NB_CIPHER_BYTES, default 184, giving the ciphertext length in bytes (1472 bits).
REQ-002 The block SHALL have parameter NB_TAG_BYTES, default 16, giving the tag length in bytes (128 bits).
REQ-003 The block SHALL have parameter ACK_TIMEOUT, default 15, giving the maximum cycles to wait for tx_busy_i to rise after a load.
REQ-004 Port clock_i, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 Port resetb_i, input, 1 bit: asynchronous reset, active-low.
REQ-006 Port start_i, input, 1 bit: single-cycle request to transmit the current cipher and tag.
REQ-007 Port cipher_i, input, NB_CIPHER_BYTES*8 bits: ciphertext from the ASCON stage.
REQ-008 Port tag_i, input, NB_TAG_BYTES*8 bits: authentication tag from the ASCON stage.
REQ-009 Port tx_busy_i, input, 1 bit: UART transmitter busy flag.
REQ-010 Port tx_byte_o, output, 8 bits: byte presented to the UART transmitter.
REQ-011 Port load_o, output, 1 bit: single-cycle load strobe to the UART transmitter.
REQ-012 Port busy_o, output, 1 bit: high whenever the state is not IDLE.
REQ-013 Port done_o, output, 1 bit: single-cycle pulse after the last byte has finished transmitting.

Function
REQ-014 When start_i=1 in IDLE, the block SHALL capture {cipher_i, tag_i} into an internal shift buffer on the same edge and go to LOAD.
REQ-015 start_i SHALL be ignored in every state other than IDLE.
REQ-016 The byte order SHALL be the cipher, most significant byte first (cipher_i[1471:1464] first), then the tag, most significant byte first.
REQ-017 The FSM SHALL have exactly the states IDLE, LOAD, WAIT_ACK, WAIT_IDLE and DONE.
REQ-018 In LOAD with tx_busy_i=0, the block SHALL drive tx_byte_o with the current byte, assert load_o for exactly one cycle and go to WAIT_ACK; with tx_busy_i=1 it SHALL stay in LOAD with load_o=0.
REQ-019 WAIT_ACK SHALL go to WAIT_IDLE when tx_busy_i=1, or when ACK_TIMEOUT cycles have elapsed, whichever comes first.
REQ-020 WAIT_IDLE SHALL hold until tx_busy_i=0, then shift the buffer by 8 bits and increment the byte counter.
REQ-021 On leaving WAIT_IDLE, the FSM SHALL go to DONE if the counter equals the total byte count, otherwise to LOAD.
REQ-022 DONE SHALL assert done_o for one cycle and return to IDLE.
REQ-023 tx_byte_o SHALL remain stable from the load_o cycle until the next shift.
REQ-024 The byte counter SHALL be 8 bits wide, SHALL never wrap, and SHALL clear on every accepted start_i.
REQ-025 The total byte count SHALL be NB_CIPHER_BYTES+NB_TAG_BYTES, i.e. 200 at default parameters.

Reset
REQ-026 While resetb_i=0, the block SHALL force state=IDLE, tx_byte_o=0x00, load_o=0, busy_o=0, done_o=0, counter=0 and buffer=0, including when a transfer is in progress.
REQ-027 After reset release, the block SHALL wait for a new start_i and SHALL NOT resume any aborted transfer.

Configuration
REQ-028 With macro TX_HEADER_EN defined, the block SHALL send the header byte 0xA5 before the first cipher byte, using the same LOAD handshake, so the total is 201 bytes.
REQ-029 With TX_HEADER_EN undefined, no header byte SHALL be sent and the total SHALL be 200 bytes.

Verification
REQ-030 Basic transfer: cipher_i = byte-index pattern (byte k = k mod 256, MSB-first), tag_i = 0xF0..0xFF, UART model busy for 10 cycles after each load -> 200 load_o pulses, bytes 0x00..0xB7 then 0xF0..0xFF, and one done_o pulse.
REQ-031 Back-pressure: tx_busy_i held at 1 when start_i arrives -> no load_o until tx_busy_i falls, then first byte 0x00.
REQ-032 Ack timeout: UART model never raises tx_busy_i -> each byte advances after 15 cycles in WAIT_ACK, and the transfer completes with 200 loads.
REQ-033 Mid-transfer reset: resetb_i low after byte 50 -> all outputs 0 within the reset assertion; a new start_i then restarts at byte 0.
REQ-034 Start while busy: a second start_i pulse at byte 10 with a different cipher_i -> ignored, and the output matches the first snapshot.
REQ-035 TX_HEADER_EN build: same stimulus as REQ-030 -> first byte 0xA5, 201 loads, done_o once.

Source files
------------

// File: rtl/cipher_tx_serializer.sv
// cipher_tx_serializer: streams {cipher, tag} byte by byte into a UART transmitter
// using a load/busy handshake with a bounded wait for the busy acknowledge.
// Optional build macro TX_HEADER_EN prepends the header byte 0xA5 to every transfer.
module cipher_tx_serializer #(
  parameter int unsigned NB_CIPHER_BYTES = 184,
  parameter int unsigned NB_TAG_BYTES    = 16,
  parameter int unsigned ACK_TIMEOUT     = 15
) (
  input  logic                         clock_i,
  input  logic                         resetb_i,
  input  logic                         start_i,
  input  logic [NB_CIPHER_BYTES*8-1:0] cipher_i,
  input  logic [NB_TAG_BYTES*8-1:0]    tag_i,
  input  logic                         tx_busy_i,
  output logic [7:0]                   tx_byte_o,
  output logic                         load_o,
  output logic                         busy_o,
  output logic                         done_o
);

`ifdef TX_HEADER_EN
  localparam int unsigned NB_HDR   = 1;
  localparam logic [7:0]  HDR_BYTE = 8'hA5;
`else
  localparam int unsigned NB_HDR   = 0;
`endif
  localparam int unsigned NB_TOTAL = NB_CIPHER_BYTES + NB_TAG_BYTES + NB_HDR;
  localparam int unsigned W_BUF    = NB_TOTAL * 8;
  localparam int unsigned W_TMO    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_ACK,
    WAIT_IDLE,
    DONE
  } state_t;

  state_t             r_state;
  logic [W_BUF-1:0]   r_buf;
  logic [7:0]         r_cnt;
  logic [W_TMO-1:0]   r_tmo;

  logic [W_BUF-1:0]   w_capture;
  logic [7:0]         w_cur_byte;
  logic [7:0]         w_cnt_inc;
  logic               w_last;
  logic               w_ack_expired;

  // Snapshot layout: optional header in the top byte, then cipher, then tag
`ifdef TX_HEADER_EN
  assign w_capture = {HDR_BYTE, cipher_i, tag_i};
`else
  assign w_capture = {cipher_i, tag_i};
`endif

  // The byte to send is always the top byte of the shift buffer
  assign w_cur_byte    = r_buf[W_BUF-1 -: 8];
  // Byte counter saturates instead of wrapping
  assign w_cnt_inc     = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
  assign w_last        = (w_cnt_inc == 8'(NB_TOTAL));
  assign w_ack_expired = (r_tmo == W_TMO'(ACK_TIMEOUT - 1));

  // Transfer FSM with registered strobes and buffer/counter management
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_state   <= IDLE;
      r_buf     <= '0;
      r_cnt     <= 8'd0;
      r_tmo     <= '0;
      tx_byte_o <= 8'h00;
      load_o    <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      load_o <= 1'b0;
      done_o <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_buf   <= w_capture;
            r_cnt   <= 8'd0;
            busy_o  <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (!tx_busy_i) begin
            tx_byte_o <= w_cur_byte;
            load_o    <= 1'b1;
            r_tmo     <= '0;
            r_state   <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (tx_busy_i || w_ack_expired) begin
            r_state <= WAIT_IDLE;
          end else begin
            r_tmo <= r_tmo + W_TMO'(1);
          end
        end
        WAIT_IDLE: begin
          if (!tx_busy_i) begin
            r_buf <= r_buf << 8;
            r_cnt <= w_cnt_inc;
            if (w_last) begin
              done_o  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_state <= LOAD;
            end
          end
        end
        DONE: begin
          busy_o  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy_o  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cipher_tx_serializer.sv
// Self-checking bench for cipher_tx_serializer: a queue-based reference of the byte
// stream is derived from the applied cipher/tag, and a monitor compares every load.
module tb_cipher_tx_serializer;

  localparam int unsigned NBC = 184;
  localparam int unsigned NBT = 16;
`ifdef TX_HEADER_EN
  localparam int unsigned HDR       = 1;
  localparam int unsigned TOTAL_LIT = 201;
  localparam logic [7:0]  FIRST_LIT = 8'hA5;
`else
  localparam int unsigned HDR       = 0;
  localparam int unsigned TOTAL_LIT = 200;
  localparam logic [7:0]  FIRST_LIT = 8'h00;
`endif
  // 15 cycles in WAIT_ACK + one WAIT_IDLE + one LOAD between successive loads
  localparam int unsigned TMO_PERIOD = 17;

  logic             clk = 1'b0;
  logic             resetb = 1'b0;
  logic             start = 1'b0;
  logic             tx_busy = 1'b0;
  logic [NBC*8-1:0] cipher = '0;
  logic [NBT*8-1:0] tag = '0;
  logic [7:0]       tx_byte;
  logic             load;
  logic             busy;
  logic             done;

  cipher_tx_serializer #(
    .NB_CIPHER_BYTES (NBC),
    .NB_TAG_BYTES    (NBT),
    .ACK_TIMEOUT     (15)
  ) dut (
    .clock_i   (clk),
    .resetb_i  (resetb),
    .start_i   (start),
    .cipher_i  (cipher),
    .tag_i     (tag),
    .tx_busy_i (tx_busy),
    .tx_byte_o (tx_byte),
    .load_o    (load),
    .busy_o    (busy),
    .done_o    (done)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         done_cnt = 0;
  int         cyc = 0;
  int         last_load_cyc = 0;
  bit         tmo_mode = 1'b0;
  bit         ack_mode = 1'b1;
  bit         force_busy = 1'b0;
  int         uart_cnt = 0;
  bit         prev_load = 1'b0;
  bit         prev_done = 1'b0;
  logic [7:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference stream: optional header, cipher MSB-first, then tag MSB-first
  task automatic build_exp();
    exp_q.delete();
`ifdef TX_HEADER_EN
    exp_q.push_back(8'hA5);
`endif
    for (int k = 0; k < int'(NBC); k++) exp_q.push_back(cipher[(int'(NBC) - 1 - k)*8 +: 8]);
    for (int j = 0; j < int'(NBT); j++) exp_q.push_back(tag[(int'(NBT) - 1 - j)*8 +: 8]);
  endtask

  task automatic set_pattern(input int seed);
    for (int k = 0; k < int'(NBC); k++) cipher[(int'(NBC) - 1 - k)*8 +: 8] = 8'(k + seed);
    for (int j = 0; j < int'(NBT); j++) tag[(int'(NBT) - 1 - j)*8 +: 8] = 8'(240 + j);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic start_xfer();
    build_exp();
    rx_q.delete();
    pulse_start();
  endtask

  task automatic wait_loads(input int n, input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rx_q.size() >= n) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_loads_reached"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0 = done_cnt;
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt != d0) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    chk({name, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    chk({name, "_load_total"}, 32'(rx_q.size()), 32'(TOTAL_LIT));
    chk({name, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  // Hand-computed bytes of the seed-0 pattern with tag 0xF0..0xFF
  task automatic check_literals(input string name);
    chk({name, "_first"}, 32'(rx_q[0]), 32'(FIRST_LIT));
    chk({name, "_cipher0"}, 32'(rx_q[HDR]), 32'h00);
    chk({name, "_cipher183"}, 32'(rx_q[HDR + 183]), 32'hB7);
    chk({name, "_tag0"}, 32'(rx_q[HDR + 184]), 32'hF0);
    chk({name, "_tag15"}, 32'(rx_q[HDR + 199]), 32'hFF);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_tx_byte"}, 32'(tx_byte), 32'h00);
    chk({name, "_load"}, 32'(load), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_done"}, 32'(done), 32'd0);
  endtask

  // Cycle counter for load spacing
  always @(posedge clk) cyc <= cyc + 1;

  // UART model: busy for 10 cycles after each load when acknowledging, or held by force
  always @(negedge clk) begin
    if (!resetb) begin
      uart_cnt = 0;
    end else if (ack_mode && load) begin
      uart_cnt = 10;
    end
    tx_busy = force_busy || (uart_cnt > 0);
    if (uart_cnt > 0) uart_cnt = uart_cnt - 1;
  end

  // Compare every load and done pulse against the reference stream
  always @(negedge clk) begin
    if (resetb) begin
      if (load) begin
        chk("load_single_cycle", 32'(prev_load), 32'd0);
        if (rx_q.size() < exp_q.size()) begin
          mon_exp = exp_q[rx_q.size()];
          chk($sformatf("byte%0d", rx_q.size()), 32'(tx_byte), 32'(mon_exp));
        end else begin
          chk("load_overrun", 32'(rx_q.size()), 32'(exp_q.size() - 1));
        end
        if (tmo_mode && rx_q.size() > 0)
          chk("timeout_spacing", 32'(cyc - last_load_cyc), 32'(TMO_PERIOD));
        last_load_cyc = cyc;
        rx_q.push_back(tx_byte);
      end
      if (done) begin
        chk("done_single_cycle", 32'(prev_done), 32'd0);
        chk("done_after_all_bytes", 32'(rx_q.size()), 32'(exp_q.size()));
        done_cnt++;
      end
      prev_load = load;
      prev_done = done;
    end else begin
      prev_load = 1'b0;
      prev_done = 1'b0;
    end
  end

  initial begin
    int snap;
    set_pattern(0);
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    resetb = 1'b1;
    repeat (2) @(negedge clk);

    // Basic transfer with a 10-cycle busy UART
    start_xfer();
    wait_done(8000, "basic");
    check_literals("basic");

    // Back-pressure: busy already high when start arrives
    force_busy = 1'b1;
    repeat (2) @(negedge clk);
    start_xfer();
    repeat (20) @(negedge clk);
    chk("bp_no_load", 32'(rx_q.size()), 32'd0);
    chk("bp_busy_out", 32'(busy), 32'd1);
    force_busy = 1'b0;
    wait_loads(1, 50, "bp");
    chk("bp_first_byte", 32'(rx_q[0]), 32'(FIRST_LIT));
    wait_done(8000, "bp");

    // Acknowledge timeout: UART never raises busy
    ack_mode = 1'b0;
    tmo_mode = 1'b1;
    start_xfer();
    wait_done(6000, "tmo");
    tmo_mode = 1'b0;
    ack_mode = 1'b1;
    check_literals("tmo");

    // Reset in the middle of a transfer, then a clean restart
    start_xfer();
    wait_loads(50, 2000, "mrst");
    @(negedge clk);
    resetb = 1'b0;
    #2;
    check_reset_outputs("mrst_in_reset");
    snap = rx_q.size();
    repeat (3) @(negedge clk);
    check_reset_outputs("mrst_held");
    resetb = 1'b1;
    repeat (40) @(negedge clk);
    chk("mrst_no_resume", 32'(rx_q.size()), 32'(snap));
    chk("mrst_idle_busy", 32'(busy), 32'd0);
    start_xfer();
    wait_done(8000, "mrst_restart");
    check_literals("mrst_restart");

    // Second start mid-transfer with different data must be ignored
    set_pattern(0);
    start_xfer();
    wait_loads(10, 1000, "sab");
    set_pattern(64);
    pulse_start();
    wait_done(8000, "sab");
    set_pattern(0);
    check_literals("sab");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
